// File: rtl/gelato_split_table.sv
// gelato_split_table: per-warp SIMT split table.
// Holds up to DEPTH divergent splits per warp, each with a valid bit, thread mask and PC.
// Serves the decoder's mask lookup and PC-advance/retire commands, branch-unit split
// requests and scheduler warp launches.
module gelato_split_table #(
   parameter int unsigned NUM_WARPS = 4,
   parameter int unsigned DEPTH     = 8,
   parameter int unsigned THREADS   = 32,
   parameter int unsigned ADDR_W    = 32,
   localparam int unsigned WARP_W   = $clog2(NUM_WARPS),
   localparam int unsigned IDX_W    = $clog2(DEPTH)
) (
   input  logic                 clk,
   input  logic                 rst,
   // decoder side
   input  logic [WARP_W-1:0]    warp_num,
   input  logic [IDX_W-1:0]     split_table_num,
   output logic [THREADS-1:0]   thread_mask,
   input  logic                 valid,
   input  logic                 stall,
   input  logic                 activate,
   input  logic [ADDR_W-1:0]    updated_pc,
   // scheduler launch
   input  logic                 launch_valid,
   input  logic [WARP_W-1:0]    launch_warp,
   input  logic [ADDR_W-1:0]    launch_pc,
   input  logic [THREADS-1:0]   launch_mask,
   // branch-unit split
   input  logic                 split_valid,
   output logic                 split_ready,
   input  logic [WARP_W-1:0]    split_warp,
   input  logic [IDX_W-1:0]     split_idx,
   input  logic [THREADS-1:0]   split_taken_mask,
   input  logic [ADDR_W-1:0]    split_taken_pc,
   input  logic [ADDR_W-1:0]    split_fall_pc,
   // scheduler query
   input  logic [WARP_W-1:0]    sched_warp,
   input  logic [IDX_W-1:0]     sched_idx,
   output logic [ADDR_W-1:0]    sched_pc,
   output logic                 sched_entry_valid,
   output logic [NUM_WARPS-1:0] warp_done
);

   logic [DEPTH-1:0]     ent_valid_q [NUM_WARPS];
   logic [DEPTH-1:0]     ent_valid_d [NUM_WARPS];
   logic [ADDR_W-1:0]    ent_pc_q    [NUM_WARPS][DEPTH];
   logic [ADDR_W-1:0]    ent_pc_d    [NUM_WARPS][DEPTH];
   logic [THREADS-1:0]   ent_mask_q  [NUM_WARPS][DEPTH];
   logic [THREADS-1:0]   ent_mask_d  [NUM_WARPS][DEPTH];
   logic [NUM_WARPS-1:0] warp_done_q;
   logic [NUM_WARPS-1:0] warp_done_d;

   logic                 dec_fire;
   logic                 dec_apply;
   logic                 par_valid;
   logic [THREADS-1:0]   par_mask;
   logic [THREADS-1:0]   taken;
   logic                 need_alloc;
   logic                 free_found;
   logic [IDX_W-1:0]     free_idx;

   // A launch to the same warp wins, so the decoder command is dropped then.
   assign dec_fire  = valid && !stall;
   assign dec_apply = dec_fire && ent_valid_q[warp_num][split_table_num]
                      && !(launch_valid && (launch_warp == warp_num));

   assign par_valid  = ent_valid_q[split_warp][split_idx];
   assign par_mask   = ent_mask_q[split_warp][split_idx];
   assign taken      = split_taken_mask & par_mask;
   assign need_alloc = (taken != '0) && (taken != par_mask);

   // Lowest-index free entry of the split warp.
   always_comb begin
      free_found = 1'b0;
      free_idx   = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (!free_found && !ent_valid_q[split_warp][IDX_W'(i)]) begin
            free_found = 1'b1;
            free_idx   = IDX_W'(i);
         end
      end
   end

   assign split_ready = split_valid && par_valid && (free_found || !need_alloc)
                        && !(dec_fire && (warp_num == split_warp) && (split_table_num == split_idx))
                        && !(launch_valid && (launch_warp == split_warp));

   assign thread_mask       = ent_valid_q[warp_num][split_table_num] ?
                              ent_mask_q[warp_num][split_table_num] : '0;
   assign sched_pc          = ent_pc_q[sched_warp][sched_idx];
   assign sched_entry_valid = ent_valid_q[sched_warp][sched_idx];
   assign warp_done         = warp_done_q;

   // Next-state table contents: decoder, then split, then launch (launch overrides its warp).
   always_comb begin
      ent_valid_d = ent_valid_q;
      ent_pc_d    = ent_pc_q;
      ent_mask_d  = ent_mask_q;
      warp_done_d = '0;

      if (dec_apply) begin
         if (activate) begin
            ent_pc_d[warp_num][split_table_num] = updated_pc;
         end else begin
            ent_valid_d[warp_num][split_table_num] = 1'b0;
            ent_mask_d[warp_num][split_table_num]  = '0;
         end
      end

      if (split_ready) begin
         if (!need_alloc) begin
            ent_pc_d[split_warp][split_idx] = (taken == '0) ? split_fall_pc : split_taken_pc;
         end else begin
            ent_mask_d[split_warp][split_idx]  = par_mask & ~taken;
            ent_pc_d[split_warp][split_idx]    = split_fall_pc;
            ent_valid_d[split_warp][free_idx]  = 1'b1;
            ent_mask_d[split_warp][free_idx]   = taken;
            ent_pc_d[split_warp][free_idx]     = split_taken_pc;
         end
      end

      if (launch_valid) begin
         ent_valid_d[launch_warp] = '0;
         for (int unsigned e = 0; e < DEPTH; e++) begin
            ent_pc_d[launch_warp][IDX_W'(e)]   = '0;
            ent_mask_d[launch_warp][IDX_W'(e)] = '0;
         end
         // An empty launch mask leaves the warp with no valid entry.
         ent_valid_d[launch_warp][0] = (launch_mask != '0);
         ent_pc_d[launch_warp][0]    = launch_pc;
         ent_mask_d[launch_warp][0]  = launch_mask;
      end

      for (int unsigned w = 0; w < NUM_WARPS; w++) begin
         warp_done_d[w] = dec_apply && !activate && (warp_num == WARP_W'(w))
                          && (ent_valid_d[w] == '0);
      end
   end

   // Table and done-pulse registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ent_valid_q <= '{default: '0};
         ent_pc_q    <= '{default: '0};
         ent_mask_q  <= '{default: '0};
         warp_done_q <= '0;
      end else begin
         ent_valid_q <= ent_valid_d;
         ent_pc_q    <= ent_pc_d;
         ent_mask_q  <= ent_mask_d;
         warp_done_q <= warp_done_d;
      end
   end

endmodule

// File: doc/gelato_split_table.md
# gelato_split_table

Per-warp SIMT split table, the slave end of the I-Decode ↔ Split Table link. It holds up to `DEPTH` divergent splits per warp, each with a thread mask and a PC. It answers the decoder's combinational mask lookup and applies the decoder's PC-advance and retire commands. It also accepts split requests from the branch unit and warp launches from the warp scheduler.

## Interface
Parameters:
- `NUM_WARPS`, 4: number of warps; `WARP_W = $clog2(NUM_WARPS)`.
- `DEPTH`, 8: split entries per warp; `IDX_W = $clog2(DEPTH)`.
- `THREADS`, 32: threads per warp; thread-mask width.
- `ADDR_W`, 32: PC width.

Ports:
- `clk` in 1: single clock; everything is rising-edge.
- `rst` in 1: asynchronous, active-high reset.
- `warp_num` in WARP_W: decoder-selected warp.
- `split_table_num` in IDX_W: decoder-selected entry.
- `thread_mask` out THREADS: combinational mask of entry (`warp_num`, `split_table_num`); 0 if the entry is invalid.
- `valid` in 1: decoder command present.
- `stall` in 1: decoder stalled; the command is ignored while high.
- `activate` in 1: 1 = advance entry PC, 0 = retire entry.
- `updated_pc` in ADDR_W: new PC when `activate` = 1.
- `launch_valid` in 1: scheduler warp launch.
- `launch_warp` in WARP_W: warp being launched.
- `launch_pc` in ADDR_W: initial PC.
- `launch_mask` in THREADS: initial mask.
- `split_valid` in 1: branch-unit split request.
- `split_ready` out 1: split accepted this cycle.
- `split_warp` in WARP_W: warp of the split.
- `split_idx` in IDX_W: parent entry.
- `split_taken_mask` in THREADS: threads taking the branch.
- `split_taken_pc` in ADDR_W: branch target.
- `split_fall_pc` in ADDR_W: fall-through PC.
- `sched_warp` in WARP_W: scheduler query warp.
- `sched_idx` in IDX_W: scheduler query entry.
- `sched_pc` out ADDR_W: combinational PC of the queried entry.
- `sched_entry_valid` out 1: combinational valid of the queried entry.
- `warp_done` out NUM_WARPS: registered one-cycle pulse when a warp's last valid entry is retired.

## Operation
- **Storage:** per (warp, entry): `ent_valid`, `ent_pc[ADDR_W]`, `ent_mask[THREADS]`.
- **Decoder commands:** a command is accepted when `valid && !stall`.
  - With `activate` = 1: `ent_pc <= updated_pc`.
  - With `activate` = 0: `ent_valid <= 0` and `ent_mask <= 0`.
  - A command addressed to an invalid entry has no effect.
- **Launch:** when `launch_valid` is high, every entry of `launch_warp` is cleared. Entry 0 is then loaded with valid = 1, pc = `launch_pc`, mask = `launch_mask`. A `launch_mask` of 0 leaves the warp empty and produces no `warp_done`.
- **Split:** let `P` be the mask of the parent entry (`split_warp`, `split_idx`), and `t = split_taken_mask & P`.
  - `t` = 0: the parent pc is set to `split_fall_pc`. No allocation.
  - `t` = P: the parent pc is set to `split_taken_pc`. No allocation.
  - Otherwise: the parent mask becomes `P & ~t` and the parent pc becomes `split_fall_pc`. The lowest-index free entry of the warp is loaded with mask = `t` and pc = `split_taken_pc`.
- **`split_ready`:** combinational, high only when all of the following hold:
  - the parent is valid;
  - a free entry exists, or no allocation is needed;
  - this cycle has no accepted decoder command to the same (warp, `split_idx`);
  - this cycle has no launch to `split_warp`.
  - A split to an invalid parent gets `split_ready` = 0 and is never accepted.
- **Collisions:** a launch wins over any decoder command or split to the same warp in the same cycle; those are dropped. A decoder command and a split to different entries or warps both apply in the same cycle.
- **`warp_done[w]`:** pulses for one cycle after an accepted retire leaves warp `w` with no valid entries.

## Timing
- **Reset:** all `ent_valid`, `ent_pc` and `ent_mask` are 0. `warp_done` is 0. `thread_mask`, `sched_pc` and `sched_entry_valid` read 0, and `split_ready` is 0.
- **Reset mid-operation:** clears all state immediately. Accepted-but-unclocked commands are lost.
- **Read outputs** (`thread_mask`, `sched_pc`, `sched_entry_valid`, `split_ready`) are combinational from registered state. There is no bypass: writes are visible the cycle after the clock edge.
- **Write latency:** every write takes effect at the next rising edge; `warp_done` asserts at that same edge.
- **Allocation:** the free-entry search is a priority encoder over the warp's `ent_valid` bits, lowest index first. The table full at `DEPTH` entries gives `split_ready` = 0.

## Test plan
- **Launch and read:** launch warp 1, pc 0x1000, mask 0xFFFFFFFF → next cycle, `thread_mask` for (1, 0) = 0xFFFFFFFF, `sched_pc` = 0x1000, entries (1, 1..7) invalid.
- **Split:** on the launched warp, split idx 0 with taken 0x0000FFFF, target 0x2000, fall-through 0x1004 → entry 0 has mask 0xFFFF0000, pc 0x1004; entry 1 has mask 0x0000FFFF, pc 0x2000. A split with taken 0xFFFFFFFF and target 0x3000 → no allocation; entry 0 pc = 0x3000.
- **Decoder activate/stall:** `valid` = 1, `activate` = 1, `updated_pc` 0x1008 on (1, 0) → pc updates. The same command with `stall` = 1 → pc unchanged.
- **Retire and done:** retire (1, 1), then retire (1, 0) → `warp_done[1]` pulses once, only after the second retire. `thread_mask` then reads 0.
- **Full and collision:** fill warp 0 to 8 entries → `split_ready` = 0. A split and an accepted decoder command to the same entry in one cycle → `split_ready` = 0 and the decoder write applies. A launch plus a split to the same warp → only the launch applies.
- **Async reset:** assert `rst` mid-split → all outputs are 0 immediately, before any clock edge. After release, the table is empty.
